// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter
//   Shares the single integer register-file write port between the 1-cycle
//   ALU and the multi-cycle MUL/DIV units. The ALU always wins. MUL and DIV
//   results wait in small per-unit FIFOs and drain round-robin into idle
//   slots. A starvation counter requests a one-cycle ALU issue bubble, so
//   buffered results are guaranteed a slot eventually.
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     alu_wr_en/rd_addr/wr_data/tag ALU writeback (cannot be back-pressured)
//     mul_valid/ready/rd_addr/data/tag  MUL result handshake
//     div_valid/ready/rd_addr/data/tag  DIV result handshake
//     alu_issue_stall               one-cycle ALU issue bubble request (registered)
//     rf_wr_en/addr/data/tag/src    registered register-file write port
//                                   (src: 00 ALU, 01 MUL, 10 DIV)

// exu_wb_fifo
//   Result buffer for one unit. The pointers carry one extra wrap bit, which
//   tells full apart from empty.
//   Ports: push/push_data in, pop/pop_data out, empty/full status.
module exu_wb_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic         full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: it is only read through valid pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module exu_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_wr_en,
    input  logic [4:0]      alu_rd_addr,
    input  logic [XLEN-1:0] alu_wr_data,
    input  logic [XLEN-1:0] alu_tag,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic [4:0]      mul_rd_addr,
    input  logic [XLEN-1:0] mul_data,
    input  logic [XLEN-1:0] mul_tag,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [4:0]      div_rd_addr,
    input  logic [XLEN-1:0] div_data,
    input  logic [XLEN-1:0] div_tag,
    output logic            alu_issue_stall,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic [XLEN-1:0] rf_wr_tag,
    output logic [1:0]      rf_wr_src
);
    localparam int unsigned EW = 5 + 2 * XLEN;
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MUL = 2'b01,
        SRC_DIV = 2'b10
    } src_e;

    typedef enum logic {
        RR_MUL = 1'b0,
        RR_DIV = 1'b1
    } rr_e;

    logic          ready_en;
    logic          mul_push, div_push, mul_pop, div_pop;
    logic          mul_empty, div_empty, mul_full, div_full;
    logic [EW-1:0] mul_head, div_head;
    logic          alu_act, any_ne;
    logic          grant_vld, fifo_grant, rr_flip;
    src_e          grant_src;
    rr_e           rr;
    logic [4:0]      g_addr;
    logic [XLEN-1:0] g_data, g_tag;
    logic [CW-1:0] starve_cnt, starve_nxt;

    // Ready is the pre-pop full flag only, so there is no combinational
    // path from the grant back into the units' handshake.
    assign mul_ready = ready_en & ~mul_full;
    assign div_ready = ready_en & ~div_full;

    // Writes to x0 are accepted but never stored.
    assign mul_push = mul_valid & mul_ready & (mul_rd_addr != 5'd0);
    assign div_push = div_valid & div_ready & (div_rd_addr != 5'd0);

    exu_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_mul_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (mul_push),
        .push_data ({mul_rd_addr, mul_data, mul_tag}),
        .pop       (mul_pop),
        .pop_data  (mul_head),
        .empty     (mul_empty),
        .full      (mul_full)
    );

    exu_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_div_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (div_push),
        .push_data ({div_rd_addr, div_data, div_tag}),
        .pop       (div_pop),
        .pop_data  (div_head),
        .empty     (div_empty),
        .full      (div_full)
    );

    assign alu_act = alu_wr_en & (alu_rd_addr != 5'd0);
    assign any_ne  = ~mul_empty | ~div_empty;

    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_ALU;
        mul_pop   = 1'b0;
        div_pop   = 1'b0;
        rr_flip   = 1'b0;
        if (alu_act) begin
            grant_vld = 1'b1;
        end else if (!mul_empty && !div_empty) begin
            grant_vld = 1'b1;
            rr_flip   = 1'b1;
            if (rr == RR_MUL) begin
                grant_src = SRC_MUL;
                mul_pop   = 1'b1;
            end else begin
                grant_src = SRC_DIV;
                div_pop   = 1'b1;
            end
        end else if (!mul_empty) begin
            grant_vld = 1'b1;
            grant_src = SRC_MUL;
            mul_pop   = 1'b1;
        end else if (!div_empty) begin
            grant_vld = 1'b1;
            grant_src = SRC_DIV;
            div_pop   = 1'b1;
        end
    end

    assign fifo_grant = mul_pop | div_pop;

    always_comb begin
        g_addr = alu_rd_addr;
        g_data = alu_wr_data;
        g_tag  = alu_tag;
        if (mul_pop)      {g_addr, g_data, g_tag} = mul_head;
        else if (div_pop) {g_addr, g_data, g_tag} = div_head;
    end

    // Counts ALU wins over a waiting FIFO head, saturating at the limit.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!any_ne || fifo_grant)
            starve_nxt = '0;
        else if (alu_act && starve_cnt != STARVE_LIM)
            starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en        <= 1'b0;
            rr              <= RR_MUL;
            starve_cnt      <= '0;
            alu_issue_stall <= 1'b0;
            rf_wr_en        <= 1'b0;
            rf_wr_addr      <= '0;
            rf_wr_data      <= '0;
            rf_wr_tag       <= '0;
            rf_wr_src       <= '0;
        end else begin
            ready_en   <= 1'b1;
            starve_cnt <= starve_nxt;
            // Pulse only on the transition into saturation.
            alu_issue_stall <= (starve_nxt == STARVE_LIM) && (starve_cnt != STARVE_LIM);
            if (rr_flip)
                rr <= (rr == RR_MUL) ? RR_DIV : RR_MUL;
            rf_wr_en <= grant_vld;
            if (grant_vld) begin
                rf_wr_addr <= g_addr;
                rf_wr_data <= g_data;
                rf_wr_tag  <= g_tag;
                rf_wr_src  <= grant_src;
            end
        end
    end
endmodule
